mem_stage_lsu: RTL and testbench

- MEM-stage load/store unit between the EX/MEM pipeline register and the MEM/WB buffer.
- Takes the address (ALU result), store data and memory control from EX/MEM.
- Runs a request/acknowledge transaction with a variable-latency data memory and stalls the pipeline until the transaction completes.
- Delivers aligned, extended load data on O_ReDat_Mem for MEM/WB to capture.

---
 rtl/mem_stage_lsu_pkg.sv | 34 +++
 rtl/mem_stage_lsu_if.sv | 24 ++
 rtl/mem_stage_lsu_align.sv | 42 ++++
 rtl/mem_stage_lsu.sv | 134 +++++++++++++
 tb/tb_mem_stage_lsu.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings and helpers for the MEM-stage load/store unit.
// The optional bus watchdog is enabled with the LSU_TIMEOUT_EN macro.
package mem_stage_lsu_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [31:0] TO_SENTINEL = 32'hDEADBEEF;

  typedef struct packed {
    logic                 we;
    logic [NUM_LANES-1:0] be;
    logic [31:0]          wdata;
  } lsu_wr_t;

  // Reserved size 2'b11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return |lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Request/acknowledge bus between the LSU (master) and data memory (slave).
interface mem_stage_lsu_if
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
);
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_addr;
  logic [31:0]          mem_wdata;
  logic [NUM_LANES-1:0] mem_be;
  logic                 mem_ack;
  logic [31:0]          mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extract/extend
// and misalignment detection. Kept standalone so a fetch path can reuse it.
module mem_stage_lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [1:0]           size,
  input  logic [1:0]           addr_lo,
  input  logic                 unsgn,
  input  logic [31:0]          wr_data,
  input  logic [31:0]          rd_word,
  output logic [NUM_LANES-1:0] be,
  output logic [31:0]          wdata,
  output logic [31:0]          ld_data,
  output logic                 misalign
);
  logic [7:0]  ld_b;
  logic [15:0] ld_h;

  always_comb begin
    be      = '1;
    wdata   = wr_data;
    ld_data = rd_word;
    ld_b    = rd_word[{addr_lo, 3'b000} +: 8];
    ld_h    = rd_word[{addr_lo[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << addr_lo;
        wdata   = {4{wr_data[7:0]}};
        ld_data = {{24{~unsgn & ld_b[7]}}, ld_b};
      end
      SZ_HALF: begin
        be      = 4'b0011 << addr_lo;
        wdata   = {2{wr_data[15:0]}};
        ld_data = {{16{~unsgn & ld_h[15]}}, ld_h};
      end
      default: ;
    endcase
  end

  assign misalign = is_misaligned(size, addr_lo);

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: issues one registered memory transaction per aligned access and
// stalls the pipeline until ack. LSU_TIMEOUT_EN adds a BUSY-state watchdog.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              I_MemRead,
  input  logic              I_MemWrite,
  input  logic [1:0]        I_Size,
  input  logic              I_Unsigned,
  input  logic [ADDR_W-1:0] I_ALU_Res,
  input  logic [31:0]       I_WrDat,
  mem_stage_lsu_if.master   bus,
  output logic [31:0]       O_ReDat_Mem,
  output logic              O_Stall,
  output logic              O_Misalign
);
  lsu_state_e           state, state_nx;
  logic                 access, mis, start, mis_now, tmo, to_hit, err_q;
  logic [NUM_LANES-1:0] al_be;
  logic [31:0]          al_wdata, al_ld;
  lsu_wr_t              wr_q;
  logic                 req_q;
  logic [ADDR_W-1:0]    addr_q;

  // The watchdog counter is 8 bits wide.
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..256");
  end

  assign access = I_MemRead | I_MemWrite;

  mem_stage_lsu_align u_align (
    .size     (I_Size),
    .addr_lo  (I_ALU_Res[1:0]),
    .unsgn    (I_Unsigned),
    .wr_data  (I_WrDat),
    .rd_word  (bus.mem_rdata),
    .be       (al_be),
    .wdata    (al_wdata),
    .ld_data  (al_ld),
    .misalign (mis)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    O_Stall  = 1'b0;
    start    = 1'b0;
    mis_now  = 1'b0;
    tmo      = 1'b0;
    case (state)
      IDLE: if (access) begin
        if (mis) mis_now = 1'b1;
        else begin
          O_Stall  = 1'b1;
          start    = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        O_Stall = 1'b1;
        if (bus.mem_ack) state_nx = DONE;
        else if (to_hit) begin
          tmo      = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Load data is extracted from live inputs at ack: EX/MEM is frozen during BUSY.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q       <= 1'b0;
      wr_q        <= '0;
      addr_q      <= '0;
      O_ReDat_Mem <= '0;
    end else begin
      if (start) begin
        req_q  <= 1'b1;
        wr_q   <= '{we: I_MemWrite, be: al_be, wdata: al_wdata};
        addr_q <= {I_ALU_Res[ADDR_W-1:2], 2'b00};
      end
      if (state == BUSY && bus.mem_ack) begin
        req_q <= 1'b0;
        if (!I_MemWrite) O_ReDat_Mem <= al_ld;
      end else if (tmo) begin
        req_q       <= 1'b0;
        O_ReDat_Mem <= TO_SENTINEL;
      end
      if (mis_now) O_ReDat_Mem <= '0;
    end
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= tmo;
      if (start)              to_cnt <= '0;
      else if (state == BUSY) to_cnt <= to_cnt + 8'd1;
    end
  end

  assign to_hit = (to_cnt == 8'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
  assign err_q  = 1'b0;
`endif

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = wr_q.we;
  assign bus.mem_be    = wr_q.be;
  assign bus.mem_wdata = wr_q.wdata;
  assign bus.mem_addr  = addr_q;
  // Misalign is a same-cycle flag; a timeout reuses it as a bus-error pulse in DONE.
  assign O_Misalign    = (mis_now & ~rst) | err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: expected transactions queued at issue,
// popped and compared when the stall releases.
module tb_mem_stage_lsu;
  import mem_stage_lsu_pkg::*;

`ifdef LSU_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        I_MemRead, I_MemWrite, I_Unsigned;
  logic [1:0]  I_Size;
  logic [31:0] I_ALU_Res, I_WrDat;
  logic [31:0] O_ReDat_Mem;
  logic        O_Stall, O_Misalign;

  always #5 clk = ~clk;

  mem_stage_lsu_if #(.ADDR_W(32)) bus ();

  mem_stage_lsu #(.ADDR_W(32), .TIMEOUT_CYC(TO_CYC)) dut (
    .clk         (clk),
    .rst         (rst),
    .I_MemRead   (I_MemRead),
    .I_MemWrite  (I_MemWrite),
    .I_Size      (I_Size),
    .I_Unsigned  (I_Unsigned),
    .I_ALU_Res   (I_ALU_Res),
    .I_WrDat     (I_WrDat),
    .bus         (bus),
    .O_ReDat_Mem (O_ReDat_Mem),
    .O_Stall     (O_Stall),
    .O_Misalign  (O_Misalign)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] redat;
    int          stalls;
    logic        mis;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;

  logic        c_req, c_req_done, c_we, c_mis;
  logic [31:0] c_addr, c_wdata, c_redat;
  logic [3:0]  c_be;
  int          c_stalls;
  bit          c_hung;

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] wd);
    I_MemRead = rd; I_MemWrite = wr; I_Size = sz; I_Unsigned = uns;
    I_ALU_Res = a;  I_WrDat = wd;
  endtask

  task automatic push(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [31:0] redat,
                      input int stalls, input logic mis);
    exp_t e;
    e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
    e.redat = redat; e.stalls = stalls; e.mis = mis;
    sb.push_back(e);
  endtask

  // Plays the memory: ack in BUSY cycle waits+1 (never if waits<0), optionally
  // repeated in the DONE cycle. Entered/left at posedge+1.
  task automatic run_txn(input int waits, input bit extra_ack, input logic [31:0] rdata);
    c_redat = 'x; c_mis = 'x; c_req_done = 'x; c_req = 'x;
    c_stalls = 0; c_hung = 1'b1;
    bus.mem_rdata = rdata;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bus.mem_ack = (waits >= 0) && ((cyc == waits + 1) || (extra_ack && cyc == waits + 2));
      @(negedge clk);
      if (cyc == 1) begin
        c_req = bus.mem_req; c_we = bus.mem_we; c_addr = bus.mem_addr;
        c_be = bus.mem_be;   c_wdata = bus.mem_wdata;
      end
      if (O_Stall) c_stalls++;
      else begin
        c_redat = O_ReDat_Mem; c_mis = O_Misalign; c_req_done = bus.mem_req; c_hung = 1'b0;
      end
      @(posedge clk); #1;
      if (!c_hung) break;
    end
    bus.mem_ack = 1'b0;
    drive(0, 0, SZ_BYTE, 0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, SZ_BYTE, 0, 32'h0, 32'h0);
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, O_ReDat_Mem, O_Misalign} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wd=%h be=%b rd=%h mis=%b, all must be 0",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, O_ReDat_Mem, O_Misalign);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (O_Stall !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_err++;
      $display("FAIL reset_idle: stall=%b req=%b, expected 0/0", O_Stall, bus.mem_req);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_load();
    exp_t e;
    drive(1, 0, SZ_WORD, 0, 32'h100, 32'h0);
    push(0, 32'h100, 4'b1111, 32'h0, 32'h8000_0001, 4, 0);
    run_txn(2, 0, 32'h8000_0001);
    e = sb.pop_front();
    n_chk++;
    if (c_hung || c_stalls !== e.stalls) begin
      n_err++; $display("FAIL word_ld_stalls: got %0d (hung=%0d) exp %0d", c_stalls, c_hung, e.stalls);
    end
    n_chk++;
    if ({c_req, c_req_done, c_we, c_addr, c_be, c_wdata, c_redat, c_mis} !==
        {1'b1, 1'b0, e.we, e.addr, e.be, e.wdata, e.redat, e.mis}) begin
      n_err++;
      $display("FAIL word_ld_bus: got req=%b/%b we=%b addr=%h be=%b wd=%h rd=%h mis=%b exp we=%b addr=%h be=%b wd=%h rd=%h mis=%b",
               c_req, c_req_done, c_we, c_addr, c_be, c_wdata, c_redat, c_mis, e.we, e.addr, e.be, e.wdata, e.redat, e.mis);
    end
  endtask

  task automatic test_byte_load();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, SZ_BYTE, 1'(i), 32'h103, 32'h0);
      push(0, 32'h100, 4'b1000, 32'h0, (i == 0) ? 32'hFFFF_FF85 : 32'h0000_0085, 2, 0);
      run_txn(0, 0, 32'h85AA_BBCC);
      e = sb.pop_front();
      n_chk++;
      if (c_hung || c_stalls !== e.stalls) begin
        n_err++; $display("FAIL byte_ld%0d_stalls: got %0d (hung=%0d) exp %0d", i, c_stalls, c_hung, e.stalls);
      end
      n_chk++;
      if ({c_req, c_req_done, c_we, c_addr, c_be, c_wdata, c_redat, c_mis} !==
          {1'b1, 1'b0, e.we, e.addr, e.be, e.wdata, e.redat, e.mis}) begin
        n_err++;
        $display("FAIL byte_ld%0d_bus: got we=%b addr=%h be=%b rd=%h mis=%b exp we=%b addr=%h be=%b rd=%h mis=%b",
                 i, c_we, c_addr, c_be, c_redat, c_mis, e.we, e.addr, e.be, e.redat, e.mis);
      end
    end
  endtask

  // Second store has read and write both set: must be treated as a store.
  task automatic test_store();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        drive(0, 1, SZ_HALF, 0, 32'h0E, 32'h0000_BEEF);
        push(1, 32'h0C, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0085, 3, 0);
      end else begin
        drive(1, 1, SZ_BYTE, 0, 32'h05, 32'h0000_0077);
        push(1, 32'h04, 4'b0010, 32'h7777_7777, 32'h0000_0085, 3, 0);
      end
      run_txn(1, 0, 32'h1234_5678);
      e = sb.pop_front();
      n_chk++;
      if (c_hung || c_stalls !== e.stalls) begin
        n_err++; $display("FAIL store%0d_stalls: got %0d (hung=%0d) exp %0d", i, c_stalls, c_hung, e.stalls);
      end
      n_chk++;
      if ({c_req, c_req_done, c_we, c_addr, c_be, c_wdata, c_redat, c_mis} !==
          {1'b1, 1'b0, e.we, e.addr, e.be, e.wdata, e.redat, e.mis}) begin
        n_err++;
        $display("FAIL store%0d_bus: got we=%b addr=%h be=%b wd=%h rd=%h exp we=%b addr=%h be=%b wd=%h rd=%h",
                 i, c_we, c_addr, c_be, c_wdata, c_redat, e.we, e.addr, e.be, e.wdata, e.redat);
      end
    end
  endtask

  task automatic test_rst_busy();
    drive(1, 0, SZ_WORD, 0, 32'h200, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_chk++;
    if (bus.mem_req !== 1'b1 || O_Stall !== 1'b1) begin
      n_err++; $display("FAIL rst_busy_pre: req=%b stall=%b, expected 1/1", bus.mem_req, O_Stall);
    end
    rst = 1'b1;
    drive(0, 0, SZ_BYTE, 0, 32'h0, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be, O_ReDat_Mem, O_Misalign, O_Stall} !== '0) begin
      n_err++;
      $display("FAIL rst_busy_post: req=%b addr=%h be=%b rd=%h stall=%b, all must be 0",
               bus.mem_req, bus.mem_addr, bus.mem_be, O_ReDat_Mem, O_Stall);
    end
    @(posedge clk); #1 bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1 bus.mem_ack = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.mem_req, O_ReDat_Mem, O_Stall, O_Misalign} !== '0) begin
      n_err++;
      $display("FAIL rst_late_ack: req=%b rd=%h stall=%b mis=%b, all must be 0", bus.mem_req, O_ReDat_Mem, O_Stall, O_Misalign);
    end
    @(posedge clk); #1;
  endtask

  // Ack repeated in DONE must be ignored; next access issues in the following cycle.
  task automatic test_back_to_back();
    exp_t e;
    push(0, 32'h08, 4'b1100, 32'h0, 32'hFFFF_8001, 2, 0);
    push(0, 32'h00, 4'b0010, 32'h0, 32'h0000_00AB, 3, 0);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        drive(1, 0, SZ_HALF, 0, 32'h0A, 32'h0);
        run_txn(0, 1, 32'h8001_1234);
      end else begin
        drive(1, 0, SZ_BYTE, 1, 32'h01, 32'h0);
        run_txn(1, 0, 32'h0000_AB00);
      end
      e = sb.pop_front();
      n_chk++;
      if (c_hung || c_stalls !== e.stalls) begin
        n_err++; $display("FAIL b2b%0d_stalls: got %0d (hung=%0d) exp %0d", i, c_stalls, c_hung, e.stalls);
      end
      n_chk++;
      if ({c_req, c_req_done, c_we, c_addr, c_be, c_wdata, c_redat, c_mis} !==
          {1'b1, 1'b0, e.we, e.addr, e.be, e.wdata, e.redat, e.mis}) begin
        n_err++;
        $display("FAIL b2b%0d_bus: got addr=%h be=%b rd=%h mis=%b exp addr=%h be=%b rd=%h mis=%b",
                 i, c_addr, c_be, c_redat, c_mis, e.addr, e.be, e.redat, e.mis);
      end
    end
  endtask

  task automatic test_misalign();
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(1, 0, SZ_WORD, 0, 32'h102, 32'h0);
      else        drive(0, 1, SZ_HALF, 0, 32'h101, 32'h1234);
      @(negedge clk);
      n_chk++;
      if ({O_Misalign, O_Stall, bus.mem_req} !== 3'b100) begin
        n_err++; $display("FAIL misalign%0d_flag: mis/stall/req=%b%b%b exp 100", i, O_Misalign, O_Stall, bus.mem_req);
      end
      @(posedge clk); #1;
      drive(0, 0, SZ_BYTE, 0, 32'h0, 32'h0);
      @(negedge clk);
      n_chk++;
      if ({O_ReDat_Mem, O_Misalign, bus.mem_req} !== 34'h0) begin
        n_err++; $display("FAIL misalign%0d_after: rd=%h mis=%b req=%b exp 0/0/0", i, O_ReDat_Mem, O_Misalign, bus.mem_req);
      end
      @(posedge clk); #1;
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    drive(1, 0, SZ_WORD, 0, 32'h300, 32'h0);
    push(0, 32'h300, 4'b1111, 32'h0, TO_SENTINEL, 1 + TO_CYC, 1);
    run_txn(-1, 0, 32'h0);
    e = sb.pop_front();
    n_chk++;
    if (c_hung || c_stalls !== e.stalls) begin
      n_err++; $display("FAIL timeout_stalls: got %0d (hung=%0d) exp %0d", c_stalls, c_hung, e.stalls);
    end
    n_chk++;
    if ({c_req, c_req_done, c_redat, c_mis} !== {1'b1, 1'b0, e.redat, e.mis}) begin
      n_err++; $display("FAIL timeout_bus: got req=%b/%b rd=%h mis=%b exp 1/0 rd=%h mis=1",
                        c_req, c_req_done, c_redat, c_mis, e.redat);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_store();
    test_rst_busy();
    test_back_to_back();
    test_misalign();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
